// File: rtl/udp_pkt_pkg.sv
// Shared constants, reader state encoding and the stream word record for
// the UDP receive packet buffer.
package udp_pkt_pkg;

  localparam int UDP_HDR_BYTES = 8;
  localparam int MAX_PAYLOAD   = 2048;

  typedef logic [1:0] rd_state_t;
  localparam rd_state_t RD_IDLE   = 2'd0;
  localparam rd_state_t RD_PRIME  = 2'd1;
  localparam rd_state_t RD_STREAM = 2'd2;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [3:0]  keep;
  } word_t;

  // Byte-enables of the final word; byte 0 sits in the top lane.
  function automatic logic [3:0] keep_from_bytes(input logic [1:0] bytes);
    case (bytes)
      2'd1:    return 4'b1000;
      2'd2:    return 4'b1100;
      2'd3:    return 4'b1110;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/udp_rx_pktbuf_if.sv
// Receive-side write bus, replay stream and status counters of the buffer.
interface udp_rx_pktbuf_if #(parameter int AW = 9) ();

  logic          data_o_valid;
  logic [31:0]   ram_wr_data;
  logic [AW-1:0] ram_wr_addr;
  logic [15:0]   rx_data_length;
  logic          data_receive;

  logic [31:0]   m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic [3:0]    m_keep;
  logic [15:0]   m_len;

  logic [15:0]   pkt_cnt;
  logic [15:0]   drop_cnt;

  modport slave (
    input  data_o_valid, ram_wr_data, ram_wr_addr, rx_data_length, data_receive,
    input  m_ready,
    output m_data, m_valid, m_last, m_keep, m_len, pkt_cnt, drop_cnt
  );

  modport master (
    output data_o_valid, ram_wr_data, ram_wr_addr, rx_data_length, data_receive,
    output m_ready,
    input  m_data, m_valid, m_last, m_keep, m_len, pkt_cnt, drop_cnt
  );

endinterface

// File: rtl/pktbuf_dpram.sv
// Simple dual-port RAM: one write port, one registered read port, one clock.
module pktbuf_dpram #(
  parameter int DEPTH = 1024,
  parameter int DW    = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/udp_rx_pktbuf.sv
// Two-bank receive packet buffer: frames land in alternating banks and are
// replayed in arrival order as a valid/ready stream with byte-enables.
module udp_rx_pktbuf #(
  parameter int BANK_WORDS  = 512,
  parameter int MAX_PAYLOAD = udp_pkt_pkg::MAX_PAYLOAD
) (
  input  logic           e_rxc,
  input  logic           reset_n,
  udp_rx_pktbuf_if.slave bus
);
  import udp_pkt_pkg::*;

  localparam int AW = $clog2(BANK_WORDS);
  localparam int WW = AW + 1;

  logic             r_in_frame, r_admit;
  logic [1:0]       r_full, w_full_nxt;
  logic             r_wr_sel, r_rd_sel;
  logic [1:0][15:0] r_len;
  logic [15:0]      r_pkt_cnt, r_drop_cnt;

  rd_state_t        r_state;
  logic [WW-1:0]    r_ridx, r_lidx, r_words;
  logic [15:0]      r_m_len;
  logic             r_rd_v, r_out_v, r_skid_v;
  word_t            r_out, r_skid;

  word_t            w_land_word, w_next;
  logic [31:0]      w_rdata;
  logic [15:0]      w_bytes;
  logic [WW-1:0]    w_words;
  logic [1:0]       w_occ;
  logic             w_pop, w_release, w_admit_now, w_cur_admit, w_len_ok;
  logic             w_close_ok, w_close_drop, w_we, w_issue, w_land;

  // ---------------- write side ----------------
  assign w_pop       = r_out_v & bus.m_ready;
  assign w_release   = w_pop & r_out.last;
  // A bank freed by the reader this cycle may be claimed by a new frame now.
  assign w_admit_now = !r_full[r_wr_sel] || (w_release && (r_rd_sel == r_wr_sel));
  assign w_cur_admit = r_in_frame ? r_admit : w_admit_now;
  assign w_we        = bus.data_o_valid & w_cur_admit;

  assign w_bytes      = bus.rx_data_length - 16'(UDP_HDR_BYTES);
  assign w_len_ok     = (bus.rx_data_length > 16'(UDP_HDR_BYTES)) &&
                        (w_bytes <= 16'(MAX_PAYLOAD));
  assign w_close_ok   = bus.data_receive & w_cur_admit & w_len_ok;
  assign w_close_drop = bus.data_receive & !w_cur_admit;

  always_comb begin
    w_full_nxt = r_full;
    if (w_release)  w_full_nxt[r_rd_sel] = 1'b0;
    if (w_close_ok) w_full_nxt[r_wr_sel] = 1'b1;
  end

  always_ff @(posedge e_rxc or negedge reset_n) begin
    if (!reset_n) begin
      r_in_frame <= 1'b0;
      r_admit    <= 1'b0;
      r_full     <= '0;
      r_wr_sel   <= 1'b0;
      r_len      <= '0;
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_full <= w_full_nxt;
      if (bus.data_receive) begin
        r_in_frame <= 1'b0;
      end else if (bus.data_o_valid && !r_in_frame) begin
        r_in_frame <= 1'b1;
        r_admit    <= w_admit_now;
      end
      if (w_close_ok) begin
        r_len[r_wr_sel] <= w_bytes;
        r_wr_sel        <= ~r_wr_sel;
        r_pkt_cnt       <= r_pkt_cnt + 16'd1;
      end
      if (w_close_drop) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  pktbuf_dpram #(
    .DEPTH (2 * BANK_WORDS),
    .DW    (32)
  ) u_ram (
    .clk     (e_rxc),
    .i_we    (w_we),
    .i_waddr ({r_wr_sel, bus.ram_wr_addr}),
    .i_wdata (bus.ram_wr_data),
    .i_raddr ({r_rd_sel, r_ridx[AW-1:0]}),
    .o_rdata (w_rdata)
  );

  // ---------------- read side ----------------
  assign w_words = WW'((r_len[r_rd_sel] + 16'd3) >> 2);
  assign w_land  = r_rd_v;
  // Words held in out/skid plus the read in flight, after this cycle's pop.
  assign w_occ   = {1'b0, r_out_v} + {1'b0, r_skid_v} + {1'b0, r_rd_v} - {1'b0, w_pop};

  always_comb begin
    w_issue = 1'b0;
    case (r_state)
      RD_IDLE:             w_issue = r_full[r_rd_sel];
      RD_PRIME, RD_STREAM: w_issue = (r_ridx < r_words) && (w_occ < 2'd2);
      default:             w_issue = 1'b0;
    endcase
  end

  always_comb begin
    w_land_word.data = w_rdata;
    w_land_word.last = (r_lidx == r_words - WW'(1));
    w_land_word.keep = w_land_word.last ? keep_from_bytes(r_m_len[1:0]) : 4'hF;
    w_next           = w_land ? w_land_word : '0;
  end

  always_ff @(posedge e_rxc or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= RD_IDLE;
      r_rd_sel <= 1'b0;
      r_ridx   <= '0;
      r_lidx   <= '0;
      r_words  <= '0;
      r_m_len  <= '0;
      r_rd_v   <= 1'b0;
      r_out_v  <= 1'b0;
      r_skid_v <= 1'b0;
      r_out    <= '0;
      r_skid   <= '0;
    end else begin
      r_rd_v <= w_issue;
      if (w_issue) r_ridx <= r_ridx + WW'(1);
      if (w_land)  r_lidx <= r_lidx + WW'(1);

      case (r_state)
        RD_IDLE: if (r_full[r_rd_sel]) begin
          r_state <= RD_PRIME;
          r_words <= w_words;
          r_m_len <= r_len[r_rd_sel];
        end
        RD_PRIME: r_state <= RD_STREAM;
        RD_STREAM: if (w_release) begin
          r_state  <= RD_IDLE;
          r_rd_sel <= ~r_rd_sel;
          r_ridx   <= '0;
          r_lidx   <= '0;
        end
        default: r_state <= RD_IDLE;
      endcase

      // Output register backed by a one-word skid; arrivals refill whichever
      // slot frees up so a stall never loses the read already in flight.
      if (w_pop) begin
        if (r_skid_v) begin
          r_out    <= r_skid;
          r_out_v  <= 1'b1;
          r_skid   <= w_next;
          r_skid_v <= w_land;
        end else begin
          r_out    <= w_next;
          r_out_v  <= w_land;
        end
      end else if (!r_out_v) begin
        r_out   <= w_next;
        r_out_v <= w_land;
      end else if (w_land) begin
        r_skid   <= w_land_word;
        r_skid_v <= 1'b1;
      end
    end
  end

  assign bus.m_data   = r_out.data;
  assign bus.m_valid  = r_out_v;
  assign bus.m_last   = r_out.last;
  assign bus.m_keep   = r_out.keep;
  assign bus.m_len    = r_m_len;
  assign bus.pkt_cnt  = r_pkt_cnt;
  assign bus.drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_udp_rx_pktbuf.sv
// Scoreboard bench for udp_rx_pktbuf: expected words are queued as frames
// are driven and popped as the stream hands them over.
module tb_udp_rx_pktbuf;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  udp_rx_pktbuf_if bus ();

  udp_rx_pktbuf #(
    .BANK_WORDS  (512),
    .MAX_PAYLOAD (2048)
  ) dut (
    .e_rxc   (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  logic [63:0] exp_q [$];
  int          cyc_q [$];
  int n_vec = 0, n_err = 0, cyc = 0, t_dr = 0;
  int rdy_mode = 0, exp_pkt = 0, exp_drop = 0;
  logic tog = 1'b0;
  logic stall_v = 1'b0;
  logic [63:0] stall_w = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    tog <= ~tog;
  end

  assign bus.m_ready = (rdy_mode == 1) || (rdy_mode == 2 && tog);

  function automatic logic [63:0] pk(input logic [31:0] d, input logic [3:0] k,
                                     input logic l, input logic [15:0] n);
    return {11'd0, n, k, l, d};
  endfunction

  function automatic logic [3:0] keep_of(input int bytes);
    case (bytes % 4)
      1:       return 4'b1000;
      2:       return 4'b1100;
      3:       return 4'b1110;
      default: return 4'b1111;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Stream monitor: scoreboard compare on accept, hold check while stalled.
  always @(negedge clk) begin
    logic [63:0] cur;
    cur = pk(bus.m_data, bus.m_keep, bus.m_last, bus.m_len);
    if (!reset_n) begin
      stall_v = 1'b0;
    end else begin
      if (stall_v) begin
        chk("hold_valid", 64'(bus.m_valid), 64'd1);
        chk("hold_word", cur, stall_w);
      end
      if (bus.m_valid && bus.m_ready) begin
        cyc_q.push_back(cyc);
        chk("word_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) chk("word", cur, exp_q.pop_front());
      end
      stall_v = bus.m_valid && !bus.m_ready;
      stall_w = cur;
    end
  end

  // kind: 0 accepted, 1 invalid length, 2 dropped
  task automatic send_frame(input int nw, input logic [15:0] ulen, input logic [31:0] base,
                            input int kind, input int rdy_first);
    int bytes, words;
    bytes = int'(ulen) - 8;
    for (int i = 0; i < nw; i++) begin
      @(posedge clk); #1;
      if (i == 0 && rdy_first >= 0) rdy_mode = rdy_first;
      bus.data_o_valid = 1'b1;
      bus.ram_wr_data  = base + 32'(i);
      bus.ram_wr_addr  = 9'(i);
    end
    @(posedge clk); #1;
    bus.data_o_valid   = 1'b0;
    bus.rx_data_length = ulen;
    bus.data_receive   = 1'b1;
    t_dr = cyc;
    if (kind == 0) begin
      words = (bytes + 3) / 4;
      exp_pkt++;
      for (int w = 0; w < words; w++)
        exp_q.push_back(pk(base + 32'(w), (w == words - 1) ? keep_of(bytes) : 4'hF,
                           w == words - 1, 16'(bytes)));
    end else if (kind == 2) begin
      exp_drop++;
    end
    @(posedge clk); #1;
    bus.data_receive = 1'b0;
  endtask

  task automatic wait_valid(input int n);
    for (int i = 0; i < n; i++) begin
      if (bus.m_valid) break;
      @(posedge clk); #1;
    end
    chk("valid_timeout", 64'(bus.m_valid), 64'd1);
  endtask

  task automatic wait_drain(input int n);
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0 && !bus.m_valid) break;
      @(posedge clk); #1;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_pkt_cnt"}, 64'(bus.pkt_cnt), 64'(exp_pkt));
    chk({tag, "_drop_cnt"}, 64'(bus.drop_cnt), 64'(exp_drop));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 64'(bus.m_valid), 64'd0);
    chk({tag, "_data"},  64'(bus.m_data),  64'd0);
    chk({tag, "_last"},  64'(bus.m_last),  64'd0);
    chk({tag, "_keep"},  64'(bus.m_keep),  64'd0);
    chk({tag, "_len"},   64'(bus.m_len),   64'd0);
    chk({tag, "_pkt"},   64'(bus.pkt_cnt), 64'd0);
    chk({tag, "_drop"},  64'(bus.drop_cnt), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, %0d words still expected", exp_q.size());
    $fatal(1);
  end

  initial begin
    bus.data_o_valid   = 1'b0;
    bus.ram_wr_data    = '0;
    bus.ram_wr_addr    = '0;
    bus.rx_data_length = '0;
    bus.data_receive   = 1'b0;
    #23;
    chk_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // single packet, m_ready high
    rdy_mode = 1;
    cyc_q.delete();
    send_frame(3, 16'd18, 32'h1000_0000, 0, -1);
    chk("t1_pkt_cnt_next_cycle", 64'(bus.pkt_cnt), 64'(exp_pkt));
    wait_drain(50);
    chk("t1_accepts", 64'(cyc_q.size()), 64'd3);
    if (cyc_q.size() >= 3) begin
      chk("t1_latency", 64'(cyc_q[0] - t_dr), 64'd3);
      chk("t1_burst", 64'(cyc_q[2] - cyc_q[0]), 64'd2);
    end
    chk_cnt("t1");

    // back-pressure, m_ready toggling
    rdy_mode = 2;
    send_frame(3, 16'd18, 32'h2000_0000, 0, -1);
    wait_drain(50);
    chk_cnt("t2");

    // overflow: third full-size frame finds both banks occupied
    rdy_mode = 0;
    send_frame(512, 16'd2056, 32'h3000_0000, 0, -1);
    send_frame(512, 16'd2056, 32'h4000_0000, 0, -1);
    send_frame(512, 16'd2056, 32'h5000_0000, 2, -1);
    chk_cnt("t3_stalled");
    rdy_mode = 1;
    wait_drain(1200);
    chk_cnt("t3");

    // invalid lengths leave no trace, following frames still flow
    send_frame(1, 16'd8, 32'h6000_0000, 1, -1);
    send_frame(1, 16'd2057, 32'h6100_0000, 1, -1);
    repeat (8) @(posedge clk);
    #1;
    chk("t4_idle_valid", 64'(bus.m_valid), 64'd0);
    chk_cnt("t4_invalid");
    send_frame(5, 16'd25, 32'h7000_0000, 0, -1);
    send_frame(2, 16'd16, 32'h7100_0000, 0, -1);
    wait_drain(60);
    chk_cnt("t4");

    // release of bank 0 coincides with the next frame's first word
    rdy_mode = 0;
    send_frame(1, 16'd12, 32'h8000_0000, 0, -1);
    send_frame(2, 16'd15, 32'h8100_0000, 0, -1);
    wait_valid(20);
    send_frame(3, 16'd19, 32'h8200_0000, 0, 1);
    wait_drain(60);
    chk_cnt("t5");

    // reset in the middle of a stream
    rdy_mode = 0;
    send_frame(8, 16'd40, 32'h9000_0000, 0, -1);
    wait_valid(20);
    rdy_mode = 2;
    repeat (3) @(posedge clk);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk_zero("t6_reset");
    exp_q.delete();
    exp_pkt  = 0;
    exp_drop = 0;
    @(posedge clk); #3;
    reset_n = 1'b1;
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    send_frame(1, 16'd9, 32'hA1B2_C3D4, 0, -1);
    wait_drain(50);
    chk_cnt("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
